// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte stream -> big-endian words -> RAM write port.
// Optional trailing XOR checksum byte enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int addWidth  = 6,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 we,
  output logic [addWidth-1:0]  waddr,
  output logic [dataWidth-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 cpu_hold
);

  localparam int BPW   = dataWidth / 8;
  localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int DEPTH = 1 << addWidth;
  localparam logic [addWidth-1:0] AONE = 1;
  localparam logic [BCW-1:0]      BONE = 1;
  localparam logic [BCW-1:0]      BLAST = BCW'(BPW - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t               state, state_d;
  logic [BCW-1:0]       bcnt;
  logic [addWidth-1:0]  last_idx;
  logic [dataWidth-1:0] asm_word;
  logic [dataWidth-1:0] asm_next;
  logic                 fire;
  logic                 last_word;

  assign byte_ready = (state == HDR) || (state == DATA) || (state == CHK);
  assign fire       = byte_valid && byte_ready;
  assign busy       = (state == HDR) || (state == DATA) || (state == WRITE) || (state == CHK);
  assign done       = (state == DONE);
  assign cpu_hold   = (state != DONE);
  assign last_word  = (waddr == last_idx);
  assign asm_next   = (asm_word << 8) | dataWidth'(byte_in);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (start) state_d = HDR;
      HDR:   if (fire) state_d = DATA;
      DATA:  if (fire && (bcnt == BLAST)) state_d = WRITE;
      WRITE: begin
        if (!last_word) begin
          state_d = DATA;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end
      end
      CHK:   if (fire) state_d = DONE;
      DONE:  if (start) state_d = HDR;
      default: state_d = IDLE;
    endcase
  end

  // Control and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      bcnt     <= '0;
      last_idx <= '0;
    end else begin
      state <= state_d;
      we    <= 1'b0;
      case (state)
        HDR: begin
          if (fire) begin
            // Header 0 or anything beyond the memory depth means "fill the whole memory".
            if ((byte_in == 8'd0) || ({1'b0, byte_in} > 9'(DEPTH)))
              last_idx <= '1;
            else
              last_idx <= addWidth'(byte_in - 8'd1);
            bcnt  <= '0;
            waddr <= '0;
          end
        end
        DATA: begin
          if (fire) begin
            if (bcnt == BLAST) begin
              bcnt  <= '0;
              we    <= 1'b1;
              wdata <= asm_next;
            end else begin
              bcnt <= bcnt + BONE;
            end
          end
        end
        WRITE: if (!last_word) waddr <= waddr + AONE;
        default: ;
      endcase
    end
  end

  // Word assembler shift register
  always_ff @(posedge clk) begin
    if (state == DATA && fire) asm_word <= asm_next;
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xsum;
  logic       err_q;

  always_ff @(posedge clk) begin
    if (state == HDR && fire)       xsum <= 8'd0;
    else if (state == DATA && fire) xsum <= xsum ^ byte_in;
  end

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if ((state == IDLE || state == DONE) && start)
      err_q <= 1'b0;
    else if (state == CHK && fire)
      err_q <= (byte_in != xsum);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: basic, full depth, stalled, abort, start-while-busy,
// and (when IMEM_LOADER_CHECKSUM_EN is defined) checksum loads.
module tb_imem_loader;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    byte_in = 8'd0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic          cpu_hold;

  imem_loader #(.addWidth(AW), .dataWidth(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_viol = 0;
  logic [AW-1:0] qa[$];
  logic [DW-1:0] qd[$];

  always @(posedge clk) begin
    if (we) begin
      qa.push_back(waddr);
      qd.push_back(wdata);
      if (byte_ready) rdy_viol++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    for (int g = 0; g < gap; g++) @(negedge clk);
    @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 3; k >= 0; k--)
      send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_writes(input string tag, input int base, input logic [31:0] exp[$]);
    check({tag, "_count"}, 64'(qa.size() - base), 64'(exp.size()));
    for (int i = 0; i < exp.size() && (base + i) < qa.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(qa[base+i]), 64'(i));
      check($sformatf("%s_data%0d", tag, i), 64'(qd[base+i]), 64'(exp[i]));
    end
  endtask

  initial begin
    int base;
    logic [31:0] exp[$];

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(byte_ready), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_hold", 64'(cpu_hold), 64'd1);
    reset = 1'b0;

    // Basic two-word load
    base = qa.size();
    pulse_start();
    check("b_busy", 64'(busy), 64'd1);
    check("b_ready_hdr", 64'(byte_ready), 64'd1);
    send_byte(8'h02, 0);
    send_word(32'h20080005, 0);
    send_word(32'h00000000, 0);
    check("b_we_after_last", 64'(we), 64'd1);
    check("b_done_early", 64'(done), 64'd0);
    check("b_hold_early", 64'(cpu_hold), 64'd1);
    @(posedge clk); #1;
    check("b_done", 64'(done), 64'd1);
    check("b_busy_end", 64'(busy), 64'd0);
    check("b_hold_end", 64'(cpu_hold), 64'd0);
    check("b_we_end", 64'(we), 64'd0);
    exp = '{32'h20080005, 32'h00000000};
    check_writes("basic", base, exp);

    // Full depth via header 0, restarted from DONE
    base = qa.size();
    pulse_start();
    check("f_done_clr", 64'(done), 64'd0);
    check("f_hold_set", 64'(cpu_hold), 64'd1);
    send_byte(8'h00, 0);
    exp = {};
    for (int i = 0; i < 64; i++) begin
      send_word(32'(i), 0);
      exp.push_back(32'(i));
    end
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    check("f_done", 64'(done), 64'd1);
    check_writes("full", base, exp);

    // Stalled source with random gaps
    base = qa.size();
    pulse_start();
    send_byte(8'h03, 2);
    send_word(32'hA1B2C3D4, 3);
    send_word(32'h01234567, 3);
    send_word(32'hFEDCBA98, 3);
    wait_done();
    exp = '{32'hA1B2C3D4, 32'h01234567, 32'hFEDCBA98};
    check_writes("stall", base, exp);

    // Abort mid-load, then a one-word load
    pulse_start();
    send_byte(8'h03, 0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 * (i + 1)), 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("a_busy", 64'(busy), 64'd0);
    check("a_ready", 64'(byte_ready), 64'd0);
    check("a_waddr", 64'(waddr), 64'd0);
    check("a_hold", 64'(cpu_hold), 64'd1);
    @(negedge clk); start = 1'b1; reset = 1'b1;
    @(negedge clk); start = 1'b0; reset = 1'b0;
    check("rs_busy", 64'(busy), 64'd0);
    base = qa.size();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    check("a_hold_mid", 64'(cpu_hold), 64'd1);
    send_byte(8'hEF, 0);
    wait_done();
    check("a_hold_end", 64'(cpu_hold), 64'd0);
    exp = '{32'hDEADBEEF};
    check_writes("abort", base, exp);

    // start pulsed while busy
    base = qa.size();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'hCA, 0);
    send_byte(8'hFE, 0);
    pulse_start();
    check("sb_busy", 64'(busy), 64'd1);
    send_byte(8'hBA, 0);
    send_byte(8'hBE, 0);
    send_word(32'h5A5AA5A5, 0);
    wait_done();
    exp = '{32'hCAFEBABE, 32'h5A5AA5A5};
    check_writes("sbusy", base, exp);
    check("no_err", 64'(err), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send_byte(8'h02, 0);
    send_word(32'h01020304, 0);
    send_word(32'h10203040, 0);
    send_byte(8'h44, 0);
    wait_done();
    check("cs_ok_err", 64'(err), 64'd0);
    check("cs_ok_done", 64'(done), 64'd1);
    pulse_start();
    send_byte(8'h02, 0);
    send_word(32'h01020304, 0);
    send_word(32'h10203040, 0);
    send_byte(8'h45, 0);
    wait_done();
    check("cs_bad_err", 64'(err), 64'd1);
    check("cs_bad_done", 64'(done), 64'd1);
`endif

    check("ready_in_write", 64'(rdy_viol), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake, assembles big-endian instruction words, and drives a single-cycle write port into the instruction RAM at consecutive addresses from 0. Holds the processor stalled until the program image is fully written. This replaces simulation-only file preloading with a synthesizable load path.

## Interface

Parameters:
- addWidth, 6, instruction-memory address width; must be ≤ 8. Depth = 2**addWidth words.
- dataWidth, 32, instruction word width; must be a multiple of 8. BPW = dataWidth/8 bytes per word.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE
- byte_in  input  8  stream data byte
- byte_valid  input  1  byte_in is valid this cycle
- byte_ready  output  1  loader accepts byte_in this cycle
- we  output  1  memory write enable, one cycle per word
- waddr  output  addWidth  memory write address
- wdata  output  dataWidth  memory write data
- busy  output  1  load in progress
- done  output  1  load finished; sticky until next start or reset
- err  output  1  checksum mismatch; sticky until next start or reset (0 when checksum is compiled out)
- cpu_hold  output  1  processor stall/hold request

## Operation

- Transfer: a byte is consumed when byte_valid && byte_ready are both high on a rising edge. byte_valid may drop at any time. A byte is never consumed unless byte_ready is high.
- Stream format: one header byte N, then words × BPW data bytes, most-significant byte first. words = N, except N = 0 means 2**addWidth words. If addWidth < 8 and N > 2**addWidth, words = 2**addWidth. After the data, one optional checksum byte (see Configuration).
- States:
  - IDLE: byte_ready = 0. Moves to HDR on start.
  - HDR: byte_ready = 1. On transfer, latch the word count, clear the byte and word counters, and move to DATA.
  - DATA: byte_ready = 1. On each transfer, shift the byte into the word assembler. On the BPW-th byte, move to WRITE.
  - WRITE: byte_ready = 0. Assert we for exactly one cycle with waddr = word index and wdata = the assembled word. If this is the last word, go to CHK if checksum is compiled in, otherwise to DONE. Otherwise increment the word index and return to DATA.
  - CHK (checksum builds only): byte_ready = 1. On transfer, compare the byte with the checksum. Set err on mismatch, then go to DONE.
  - DONE: done = 1 and cpu_hold = 0. Moves to HDR on start, which clears done and err and reasserts cpu_hold.
- busy = 1 in HDR, DATA, WRITE, and CHK.
- cpu_hold = 1 from reset until DONE is reached. It stays 0 in DONE.
- start while busy is ignored.
- waddr holds the word index throughout a load. The index wraps at 2**addWidth and never exceeds depth − 1.

## Timing

- Reset values: state = IDLE, byte_ready = 0, we = 0, waddr = 0, wdata = 0, busy = 0, done = 0, err = 0, cpu_hold = 1.
- Latency: we is asserted in the cycle after the edge that accepts the last byte of a word.
- Throughput: at best BPW + 1 cycles per word, because of the one-cycle WRITE bubble.
- Signal sources: we, waddr, and wdata are registered outputs. byte_ready is decoded from state only and never depends on byte_valid.
- Mid-load reset: return to IDLE and discard the partial word. Words already written stay in memory. cpu_hold stays 1.
- start and reset in the same cycle: reset wins.
- done rises on the cycle after the final write (or after the checksum byte is accepted). busy falls on that same cycle.

## Configuration

- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all data bytes (header excluded) is kept.
  - The CHK state consumes one trailing byte.
  - err is set if that byte differs from the running XOR.
  - done is asserted regardless of err.
- Undefined:
  - No CHK state and no trailing byte.
  - err is tied to 0.

## Test plan

- Basic load: start; stream 02, 20 08 00 05, 00 00 00 00 with byte_valid held high → writes 0x20080005 at addr 0 and 0x00000000 at addr 1, one we pulse each, done = 1 and cpu_hold = 0 after the last write.
- Full depth: header 00 followed by 256 bytes (addWidth = 6) → 64 writes at addr 0..63 with data equal to word index, no write to addr 0 after 63, done = 1.
- Stalled source: random byte_valid gaps during a 3-word load → identical write sequence and data to the gap-free run; byte_ready = 0 during each WRITE cycle.
- Abort and restart: reset after 5 data bytes, then start and a 1-word load of DEADBEEF → single write of 0xDEADBEEF at addr 0; cpu_hold stays 1 until the new load is done.
- start while busy: pulse start in the middle of a 2-word load → no effect on the counters or the writes.
- Checksum (macro defined): words 01020304 and 10203040 followed by checksum 44 → err = 0. Same words followed by 45 → err = 1 and done = 1.
